ws2812_frame_ctrl: RTL and testbench
====================================

Name: ws2812_frame_ctrl

Overview:
- Upstream of the per-bit waveform generator in the BASYS 3 WS2812B LED chain.
- Reads 24-bit GRB pixel words from a pixel memory and serialises each word MSB-first.
- Drives the generator through its genMode/doGen/genDone handshake.
- Closes every frame with a timed low (latch/reset) period so the strip displays the new data.

Parameters:
ADDR_W, 8, width of pixel address and LED count
RESET_CYCLES, 6000, latch low duration in clk cycles (60 us at 100 MHz)
LAT_W, 13, width of latch counter; must satisfy 2^LAT_W > RESET_CYCLES

Ports:
clk  in  1  100 MHz system clock
reset  in  1  synchronous reset, active-high
start  in  1  single-cycle request to send one frame
num_leds  in  ADDR_W  LEDs in frame; sampled only when start is accepted
pix_rd  out  1  pixel memory read strobe
pix_addr  out  ADDR_W  pixel memory address
pix_data  in  24  GRB word, valid exactly 1 cycle after pix_rd
genMode  out  2  to generator: 10 = zero, 11 = one, 00 = ret, 01 = none
doGen  out  1  to generator: bit period enable
genDone  in  1  from generator: high for one cycle at end of bit
busy  out  1  high from accepted start until frame_done
frame_done  out  1  one-cycle pulse at end of latch

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (reset). All outputs are registered.
- Reset values: state IDLE, genMode = 01 (none), doGen = 0, pix_rd = 0, pix_addr = 0, busy = 0, frame_done = 0. All counters are cleared.
- FSM states: IDLE, FETCH, LOAD, SEND, GAP, LATCH.
- IDLE:
  - start = 1 with num_leds != 0: latch num_leds, set busy = 1, go to FETCH.
  - start = 1 with num_leds = 0: pulse frame_done for one cycle, no latch period, busy stays 0, stay IDLE.
  - genDone is ignored in IDLE.
- FETCH: pix_rd = 1, pix_addr = 0 for one cycle, then LOAD.
- LOAD:
  - Capture pix_data into the shift register and set bit index = 23.
  - Drive genMode = {1, word[23]} and doGen = 1, then SEND.
- SEND:
  - doGen stays 1, holding genMode.
  - While the current pixel's bit 23 is active and the current pixel is not the last, prefetch the next pixel: pix_rd = 1 for one cycle at pix_addr = current + 1, and capture pix_data into the next-pixel register on the following cycle.
  - On genDone = 1, go to GAP.
- GAP (exactly 1 cycle):
  - doGen = 0, which returns the generator counter to 0.
  - Load the next bit into genMode: the next lower bit of the current word, or bit 23 of the prefetched word if bit 0 has just finished.
  - Then SEND with doGen = 1.
  - If bit 0 of the last pixel has just finished, skip SEND: genMode = 00, doGen = 0, go to LATCH.
- Per-bit period: 121 cycles doGen high plus 1 GAP cycle = 122 cycles (1.22 us).
- Pixel boundaries: no extra cycles between pixels.
- LATCH:
  - genMode = 00, doGen = 0; count RESET_CYCLES cycles.
  - On the final count, pulse frame_done, clear busy, set genMode = 01, go to IDLE.
- start while busy is ignored; num_leds changes while busy are ignored.
- genDone outside SEND is ignored.
- reset asserted mid-frame: on the next edge, all outputs take their reset values and the frame is abandoned with no frame_done.
- Address arithmetic: unsigned ADDR_W bits. Last pixel address is num_leds - 1; num_leds = 2^ADDR_W - 1 is the maximum frame.

Decomposition:
- Shared package ws2812_pkg holds:
  - genMode encodings GEN_ZERO = 2'b10, GEN_ONE = 2'b11, GEN_RET = 2'b00, GEN_NONE = 2'b01.
  - BITS_PER_LED = 24.
  - BIT_CYCLES = 121.
  - FSM state encoding.
- One natural sub-module: ws2812_latch_timer. It is a loadable down-counter with a done pulse, and it is reused for any future inter-frame delay.

Test Plan:
1. Reset, then num_leds = 1, pix_data = 24'hFF0000, with a generator model asserting genDone after 121 doGen cycles. Required: genMode sequence is 11×8 then 10×16, one GAP cycle between bits, then genMode = 00 for 6000 cycles, frame_done pulse, busy low.
2. num_leds = 2 with words 24'hA5A5A5 and 24'h00FF00. Required: pix_rd at addr 0 in FETCH; pix_rd at addr 1 during pixel 0 bit 23 only; 48 bits in MSB-first order; pixel-boundary gap is exactly 1 cycle.
3. num_leds = 0 with start. Required: frame_done pulses one cycle later, busy never asserts, no pix_rd, doGen stays 0.
4. start re-pulsed at bit 5 of a 1-LED frame. Required: ignored; bit sequence and frame_done timing identical to scenario 1 (24×122 cycles plus latch).
5. reset asserted at bit 10, then released and start given. Required: doGen = 0 and genMode = 01 after the reset edge, no frame_done; the new frame restarts from pix_addr 0.
6. Spurious genDone pulses in IDLE and LATCH. Required: no state change; latch still lasts exactly 6000 cycles.

Source files
------------

// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared encodings and constants for the WS2812B frame path
package ws2812_pkg;
  localparam logic [1:0] GEN_ZERO = 2'b10;
  localparam logic [1:0] GEN_ONE  = 2'b11;
  localparam logic [1:0] GEN_RET  = 2'b00;
  localparam logic [1:0] GEN_NONE = 2'b01;

  localparam int BITS_PER_LED = 24;
  localparam int BIT_CYCLES   = 121;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SEND,
    S_GAP,
    S_LATCH
  } state_t;

  function automatic logic [1:0] bit_mode(input logic b);
    return b ? GEN_ONE : GEN_ZERO;
  endfunction
endpackage

// File: rtl/ws2812_latch_timer.sv
// rtl/ws2812_latch_timer.sv - loadable down-counter with a done pulse on its final count
module ws2812_latch_timer #(
  parameter int LAT_W = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic             done
);
  logic [LAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // A load of N gives N counting cycles; done marks the last of them.
  assign done = (cnt_q == LAT_W'(1));
endmodule

// File: rtl/ws2812_frame_ctrl.sv
// rtl/ws2812_frame_ctrl.sv - fetches GRB pixels, serialises them MSB-first to the bit
// generator and closes each frame with a timed latch low.
module ws2812_frame_ctrl
  import ws2812_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int RESET_CYCLES = 6000,
  parameter int LAT_W        = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_leds,
  output logic              pix_rd,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [23:0]       pix_data,
  output logic [1:0]        genMode,
  output logic              doGen,
  input  logic              genDone,
  output logic              busy,
  output logic              frame_done
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] last_q, last_d, cur_q, cur_d, pix_addr_q, pix_addr_d;
  logic [ADDR_W-1:0] cur_nxt;
  logic [23:0]       shift_q, shift_d, next_q, next_d;
  logic [4:0]        bit_idx_q, bit_idx_d;
  logic [1:0]        gen_mode_q, gen_mode_d;
  logic              pix_rd_q, pix_rd_d, cap_q, cap_d, do_gen_q, do_gen_d;
  logic              busy_q, busy_d, frame_done_q, frame_done_d;
  logic              tmr_load, tmr_done;

  assign cur_nxt = cur_q + 1'b1;

  ws2812_latch_timer #(.LAT_W(LAT_W)) u_latch_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (LAT_W'(RESET_CYCLES)),
    .done     (tmr_done)
  );

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    cur_d        = cur_q;
    pix_addr_d   = pix_addr_q;
    shift_d      = shift_q;
    next_d       = next_q;
    bit_idx_d    = bit_idx_q;
    gen_mode_d   = gen_mode_q;
    do_gen_d     = do_gen_q;
    busy_d       = busy_q;
    pix_rd_d     = 1'b0;
    frame_done_d = 1'b0;
    tmr_load     = 1'b0;
    // Prefetched word arrives the cycle after its read strobe.
    cap_d        = pix_rd_q && (state_q == S_SEND);
    if (cap_q) next_d = pix_data;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_leds != '0) begin
            last_d     = num_leds - 1'b1;
            cur_d      = '0;
            busy_d     = 1'b1;
            pix_rd_d   = 1'b1;
            pix_addr_d = '0;
            state_d    = S_FETCH;
          end else begin
            frame_done_d = 1'b1;
          end
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        shift_d    = pix_data;
        bit_idx_d  = 5'(BITS_PER_LED - 1);
        gen_mode_d = bit_mode(pix_data[23]);
        do_gen_d   = 1'b1;
        if (cur_q != last_q) begin
          pix_rd_d   = 1'b1;
          pix_addr_d = cur_nxt;
        end
        state_d = S_SEND;
      end
      S_SEND: begin
        if (genDone) begin
          do_gen_d = 1'b0;
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        if (bit_idx_q == '0) begin
          if (cur_q == last_q) begin
            gen_mode_d = GEN_RET;
            tmr_load   = 1'b1;
            state_d    = S_LATCH;
          end else begin
            cur_d      = cur_nxt;
            shift_d    = next_q;
            bit_idx_d  = 5'(BITS_PER_LED - 1);
            gen_mode_d = bit_mode(next_q[23]);
            do_gen_d   = 1'b1;
            if (cur_nxt != last_q) begin
              pix_rd_d   = 1'b1;
              pix_addr_d = cur_nxt + 1'b1;
            end
            state_d = S_SEND;
          end
        end else begin
          shift_d    = shift_q << 1;
          bit_idx_d  = bit_idx_q - 1'b1;
          gen_mode_d = bit_mode(shift_q[22]);
          do_gen_d   = 1'b1;
          state_d    = S_SEND;
        end
      end
      S_LATCH: begin
        if (tmr_done) begin
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
          gen_mode_d   = GEN_NONE;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_q       <= '0;
      cur_q        <= '0;
      pix_addr_q   <= '0;
      shift_q      <= '0;
      next_q       <= '0;
      bit_idx_q    <= '0;
      gen_mode_q   <= GEN_NONE;
      do_gen_q     <= 1'b0;
      busy_q       <= 1'b0;
      pix_rd_q     <= 1'b0;
      cap_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      cur_q        <= cur_d;
      pix_addr_q   <= pix_addr_d;
      shift_q      <= shift_d;
      next_q       <= next_d;
      bit_idx_q    <= bit_idx_d;
      gen_mode_q   <= gen_mode_d;
      do_gen_q     <= do_gen_d;
      busy_q       <= busy_d;
      pix_rd_q     <= pix_rd_d;
      cap_q        <= cap_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pix_rd     = pix_rd_q;
  assign pix_addr   = pix_addr_q;
  assign genMode    = gen_mode_q;
  assign doGen      = do_gen_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// tb/tb_ws2812_frame_ctrl.sv - self-checking bench for ws2812_frame_ctrl with
// pixel memory and bit generator models.
module tb_ws2812_frame_ctrl;
  import ws2812_pkg::*;

  localparam int ADDR_W       = 8;
  localparam int RESET_CYCLES = 6000;
  localparam int LAT_W        = 13;
  localparam int BIT_PERIOD   = BIT_CYCLES + 1;
  localparam int PIX_PERIOD   = BITS_PER_LED * BIT_PERIOD;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] num_leds = '0;
  logic              pix_rd;
  logic [ADDR_W-1:0] pix_addr;
  logic [23:0]       pix_data = '0;
  logic [1:0]        gen_mode;
  logic              do_gen;
  logic              gen_done;
  logic              busy;
  logic              frame_done;
  logic              spur = 1'b0;
  logic [23:0]       mem [0:255];
  int                gcnt = 0;
  int                tests = 0;
  int                fails = 0;

  always #5 clk = ~clk;

  ws2812_frame_ctrl #(
    .ADDR_W       (ADDR_W),
    .RESET_CYCLES (RESET_CYCLES),
    .LAT_W        (LAT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_leds   (num_leds),
    .pix_rd     (pix_rd),
    .pix_addr   (pix_addr),
    .pix_data   (pix_data),
    .genMode    (gen_mode),
    .doGen      (do_gen),
    .genDone    (gen_done),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Memory: word valid exactly one cycle after the strobe, garbage otherwise.
  always @(posedge clk) pix_data <= pix_rd ? mem[pix_addr] : 24'($urandom);

  // Generator: genDone on the 121st consecutive doGen-high cycle.
  always @(posedge clk) gcnt <= (do_gen && !reset) ? gcnt + 1 : 0;
  assign gen_done = (do_gen && gcnt == BIT_CYCLES - 1) || spur;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode: 0 plain, 1 start re-pulse at bit 5, 2 spurious genDone in latch, 3 reset at bit 10
  task automatic run_frame(input int n, input int mode);
    bit exp_bits[$];
    bit got_bits[$];
    int rd_addr[$];
    int rd_cyc[$];
    int cyc = 0, rise_cyc = 0, fall_cyc = -1, done_cyc = -1;
    int bad_high = 0, bad_gap = 0, bad_mode = 0, latch_cnt = 0, busy_bad = 0;
    int mism = 0, rd_bad = 0, post_bad = 0, lo = 0;
    bit prev_dg = 1'b0;
    logic [1:0] prev_mode = GEN_NONE;
    for (int p = 0; p < n; p++)
      for (int b = 23; b >= 0; b--) exp_bits.push_back(mem[p][b]);

    @(negedge clk);
    start = 1'b1;
    num_leds = ADDR_W'(n);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 30000 && done_cyc < 0) begin
      if (pix_rd) begin
        rd_addr.push_back(int'(pix_addr));
        rd_cyc.push_back(cyc);
      end
      if (do_gen && !prev_dg) begin
        got_bits.push_back(gen_mode[0]);
        if (!gen_mode[1]) bad_mode++;
        if (fall_cyc >= 0 && cyc - fall_cyc != 1) bad_gap++;
        rise_cyc = cyc;
        if (mode == 1 && got_bits.size() == 6) begin
          start = 1'b1;
          num_leds = 8'd3;
        end
        if (mode == 3 && got_bits.size() == 11) begin
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
          check("rst_do_gen", do_gen, 0);
          check("rst_gen_mode", gen_mode, GEN_NONE);
          check("rst_busy", busy, 0);
          check("rst_pix_rd", pix_rd, 0);
          for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (frame_done || do_gen || busy) post_bad++;
          end
          check("rst_abandon", post_bad, 0);
          return;
        end
      end
      if (!do_gen && prev_dg) begin
        if (cyc - rise_cyc != BIT_CYCLES) bad_high++;
        fall_cyc = cyc;
      end
      if (do_gen && prev_dg && gen_mode !== prev_mode) bad_mode++;
      if (gen_mode == GEN_RET) begin
        latch_cnt++;
        if (mode == 2 && (latch_cnt == 100 || latch_cnt == 3000)) spur = 1'b1;
      end
      if (frame_done) done_cyc = cyc;
      else if (busy !== 1'b1) busy_bad++;
      prev_dg = do_gen;
      prev_mode = gen_mode;
      @(negedge clk);
      start = 1'b0;
      spur = 1'b0;
      if (done_cyc < 0) cyc++;
    end

    check("frame_timeout", done_cyc >= 0, 1);
    check("bit_count", got_bits.size(), BITS_PER_LED * n);
    for (int i = 0; i < got_bits.size() && i < exp_bits.size(); i++)
      if (got_bits[i] != exp_bits[i]) mism++;
    check("bit_order", mism, 0);
    check("bit_high_len", bad_high, 0);
    check("bit_gap_len", bad_gap, 0);
    check("gen_mode_valid", bad_mode, 0);
    check("latch_len", latch_cnt, RESET_CYCLES);
    check("done_time", done_cyc, 2 + n * PIX_PERIOD + RESET_CYCLES + 1);
    check("rd_count", rd_addr.size(), n);
    for (int i = 0; i < rd_addr.size(); i++) begin
      if (rd_addr[i] != i) rd_bad++;
      if (i == 0) begin
        if (rd_cyc[i] != 1) rd_bad++;
      end else begin
        lo = 3 + (i - 1) * PIX_PERIOD;
        if (rd_cyc[i] < lo || rd_cyc[i] > lo + BIT_CYCLES - 1) rd_bad++;
      end
    end
    check("rd_addr_time", rd_bad, 0);
    check("busy_during", busy_bad, 0);
    check("done_busy_low", busy, 0);
    check("done_gen_mode", gen_mode, GEN_NONE);
    @(negedge clk);
    check("done_single", frame_done, 0);
    check("busy_after", busy, 0);
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 256; i++) mem[i] = 24'($urandom);

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_gen_mode", gen_mode, GEN_NONE);
    check("reset_do_gen", do_gen, 0);
    check("reset_pix_rd", pix_rd, 0);
    check("reset_pix_addr", pix_addr, 0);
    check("reset_busy", busy, 0);
    check("reset_frame_done", frame_done, 0);

    // Single LED, 8 ones then 16 zeros
    mem[0] = 24'hFF0000;
    run_frame(1, 0);

    // Two LEDs with prefetch across the pixel boundary
    mem[0] = 24'hA5A5A5;
    mem[1] = 24'h00FF00;
    run_frame(2, 0);

    // Empty frame
    @(negedge clk);
    start = 1'b1;
    num_leds = '0;
    @(negedge clk);
    start = 1'b0;
    check("empty_done", frame_done, 1);
    check("empty_busy", busy, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame_done || busy || pix_rd || do_gen) bad++;
    end
    check("empty_quiet", bad, 0);

    // Start re-pulsed mid-frame is ignored
    mem[0] = 24'($urandom);
    run_frame(1, 1);

    // Reset mid-frame, then a fresh frame from address 0
    mem[0] = 24'($urandom);
    run_frame(1, 3);
    mem[0] = 24'($urandom);
    run_frame(1, 0);

    // Spurious genDone while idle, then during the latch
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      spur = i[0];
      if (do_gen || busy || pix_rd || frame_done || gen_mode !== GEN_NONE) bad++;
    end
    @(negedge clk);
    spur = 1'b0;
    check("idle_spur", bad, 0);
    mem[0] = 24'($urandom);
    run_frame(1, 2);

    // Random three-LED frame
    for (int i = 0; i < 3; i++) mem[i] = 24'($urandom);
    run_frame(3, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
